// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling serial receiver with a one-deep holding register
// and sticky framing/overrun flags for the bus-side status register.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int TICK_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_edge,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       read_ack,
   input  logic       err_clr,
   output logic       framing_err,
   output logic       overrun,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   localparam logic [TICK_W-1:0] HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL = TICK_W'(OVERSAMPLE - 1);
   state_t            state, state_n;
   logic [TICK_W-1:0] tick_cnt, tick_n;
   logic [2:0]        bit_idx, bit_n;
   logic [7:0]        shift, shift_n;
   logic              rx_m, rx_s, deliver, stop_bad;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
      end
   // counters only move on sample_edge; the START check lands at mid start-bit
   always_comb begin
      state_n  = state;
      tick_n   = tick_cnt;
      bit_n    = bit_idx;
      shift_n  = shift;
      deliver  = 1'b0;
      stop_bad = 1'b0;
      if (sample_edge)
         case (state)
            IDLE:  if (!rx_s) begin
                      state_n = START;
                      tick_n  = '0;
                   end
            START: if (tick_cnt == HALF) begin
                      state_n = rx_s ? IDLE : DATA;
                      tick_n  = '0;
                      bit_n   = '0;
                   end else tick_n = tick_cnt + 1'b1;
            DATA:  if (tick_cnt == FULL) begin
                      shift_n = {rx_s, shift[7:1]};
                      tick_n  = '0;
                      bit_n   = bit_idx + 3'd1;
                      state_n = (bit_idx == 3'd7) ? STOP : DATA;
                   end else tick_n = tick_cnt + 1'b1;
            STOP:  if (tick_cnt == FULL) begin
                      deliver  = rx_s;
                      stop_bad = !rx_s;
                      state_n  = rx_s ? IDLE : BRK;
                      tick_n   = '0;
                   end else tick_n = tick_cnt + 1'b1;
            BRK:   state_n = rx_s ? IDLE : BRK;
            default: state_n = IDLE;
         endcase
   end
   // a same-cycle ack frees the holding register for the arriving byte
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         data        <= '0;
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (deliver && (!data_valid || read_ack)) begin
            data       <= shift;
            data_valid <= 1'b1;
         end else if (read_ack && !deliver) data_valid <= 1'b0;
         framing_err <= stop_bad | (framing_err & ~err_clr);
         overrun     <= (deliver & data_valid & ~read_ack) | (overrun & ~err_clr);
      end
   assign busy = (state != IDLE);
endmodule
